// File: rtl/projectile.sv
// -----------------------------------------------------------------------------
// projectile -- player shot controller for a vertical shooter.
//
// Launches one shot from just above the ship on a fire request, moves it
// upward by SPEED pixels per frame_tick, and retires it when it reaches the
// top of the play field or when the enemy block reports a hit. After a retire
// the launcher stays disarmed for COOLDOWN frame_ticks before it re-arms.
//
// Ports:
//   clk           single clock
//   reset         asynchronous, active-low reset
//   start         synchronous game restart (highest priority after reset)
//   frame_tick    one-cycle pulse per video frame
//   fire          player fire button, synchronous to clk
//   ship_h/v      ship position (10 bits each)
//   hit           collision flag from the enemy block
//   projectile_h/v projectile position, parked at 1000 when not in flight
//   active        projectile in flight
//   shots         count of shots launched (wraps 255 -> 0)
//
// Configuration macro:
//   PROJECTILE_AUTOFIRE_EN  defined   -> fire level launches in IDLE
//                           undefined -> only a fire rising edge launches
// -----------------------------------------------------------------------------
module projectile #(
   parameter int SPEED         = 4,
   parameter int TOP_LIMIT     = 10,
   parameter int LAUNCH_OFFSET = 20,
   parameter int COOLDOWN      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       fire,
   input  logic [9:0] ship_h,
   input  logic [9:0] ship_v,
   input  logic       hit,
   output logic [9:0] projectile_h,
   output logic [9:0] projectile_v,
   output logic       active,
   output logic [7:0] shots
);

   localparam logic [9:0]  PARK_POS   = 10'd1000;
   localparam logic [9:0]  SPEED_V    = 10'(SPEED);
   localparam logic [9:0]  OFFSET_V   = 10'(LAUNCH_OFFSET);
   // One bit wider so TOP_LIMIT + SPEED cannot wrap the comparison.
   localparam logic [10:0] RETIRE_V   = 11'(TOP_LIMIT + SPEED);
   localparam logic [7:0]  COOL_INIT  = 8'(COOLDOWN);

   typedef enum logic [2:0] {
      S_IDLE     = 3'b001,
      S_FLIGHT   = 3'b010,
      S_COOLDOWN = 3'b100
   } state_t;

   state_t     state_q, state_d;
   logic       fire_prev_q;
   logic       active_q, active_d;
   logic [9:0] pos_h_q, pos_h_d;
   logic [9:0] pos_v_q, pos_v_d;
   logic [7:0] shots_q, shots_d;
   logic [7:0] cnt_q, cnt_d;

   logic       shot_req;
   logic       do_retire;
   logic [9:0] launch_v;

`ifdef PROJECTILE_AUTOFIRE_EN
   // Level-sensitive: holding fire relaunches as soon as IDLE is re-entered.
   assign shot_req = fire;
`else
   assign shot_req = fire & ~fire_prev_q;
`endif

   // Launch height saturates at the top of the screen instead of wrapping.
   assign launch_v = (ship_v < OFFSET_V) ? 10'd0 : (ship_v - OFFSET_V);

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      pos_h_d   = pos_h_q;
      pos_v_d   = pos_v_q;
      shots_d   = shots_q;
      cnt_d     = cnt_q;
      do_retire = 1'b0;

      if (start) begin
         state_d  = S_IDLE;
         active_d = 1'b0;
         pos_h_d  = PARK_POS;
         pos_v_d  = PARK_POS;
         shots_d  = 8'd0;
         cnt_d    = 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (shot_req) begin
                  state_d  = S_FLIGHT;
                  active_d = 1'b1;
                  pos_h_d  = ship_h;
                  pos_v_d  = launch_v;
                  shots_d  = shots_q + 8'd1;
               end
            end
            S_FLIGHT: begin
               // hit wins over frame_tick; the position is not advanced.
               if (hit) begin
                  do_retire = 1'b1;
               end else if (frame_tick) begin
                  if ({1'b0, pos_v_q} <= RETIRE_V) begin
                     do_retire = 1'b1;
                  end else begin
                     pos_v_d = pos_v_q - SPEED_V;
                  end
               end
            end
            S_COOLDOWN: begin
               // A counter of 0 or 1 expires on this tick (covers COOLDOWN=0).
               if (frame_tick) begin
                  if (cnt_q <= 8'd1) begin
                     cnt_d   = 8'd0;
                     state_d = S_IDLE;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                  end
               end
            end
            default: begin
               state_d  = S_IDLE;
               active_d = 1'b0;
               pos_h_d  = PARK_POS;
               pos_v_d  = PARK_POS;
               cnt_d    = 8'd0;
            end
         endcase

         if (do_retire) begin
            state_d  = S_COOLDOWN;
            active_d = 1'b0;
            pos_h_d  = PARK_POS;
            pos_v_d  = PARK_POS;
            cnt_d    = COOL_INIT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         fire_prev_q <= 1'b0;
         active_q    <= 1'b0;
         pos_h_q     <= PARK_POS;
         pos_v_q     <= PARK_POS;
         shots_q     <= 8'd0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         fire_prev_q <= fire;
         active_q    <= active_d;
         pos_h_q     <= pos_h_d;
         pos_v_q     <= pos_v_d;
         shots_q     <= shots_d;
         cnt_q       <= cnt_d;
      end
   end

   assign projectile_h = pos_h_q;
   assign projectile_v = pos_v_q;
   assign active       = active_q;
   assign shots        = shots_q;

endmodule

// File: tb/tb_projectile.sv
// -----------------------------------------------------------------------------
// tb_projectile -- directed scoreboard bench for projectile (default params).
// The driver applies one cycle of stimulus, then pushes the outputs expected
// after that edge; the monitor pops and compares on the following negedge.
// -----------------------------------------------------------------------------
module tb_projectile;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       frame_tick;
   logic       fire;
   logic [9:0] ship_h;
   logic [9:0] ship_v;
   logic       hit;
   logic [9:0] projectile_h;
   logic [9:0] projectile_v;
   logic       active;
   logic [7:0] shots;

   projectile dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .frame_tick   (frame_tick),
      .fire         (fire),
      .ship_h       (ship_h),
      .ship_v       (ship_v),
      .hit          (hit),
      .projectile_h (projectile_h),
      .projectile_v (projectile_v),
      .active       (active),
      .shots        (shots)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       act;
      logic [9:0] h;
      logic [9:0] v;
      logic [7:0] s;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: every negedge, check all expectations queued since.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (active !== e.act || projectile_h !== e.h ||
                projectile_v !== e.v || shots !== e.s) begin
               n_bad++;
               $display("FAIL %s: got act=%0b pos=(%0d,%0d) shots=%0d, want act=%0b pos=(%0d,%0d) shots=%0d",
                        e.name, active, projectile_h, projectile_v, shots,
                        e.act, e.h, e.v, e.s);
            end else begin
               $display("ok   %s: act=%0b pos=(%0d,%0d) shots=%0d",
                        e.name, active, projectile_h, projectile_v, shots);
            end
         end
      end
   end

   task automatic expect_out(input string nm, input logic a, input int h,
                             input int v, input int s);
      exp_t e;
      e.name = nm;
      e.act  = a;
      e.h    = 10'(h);
      e.v    = 10'(v);
      e.s    = 8'(s);
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; returns 1 time unit after the sampling edge.
   task automatic cyc(input logic f, input logic ft, input logic h, input logic st);
      fire       = f;
      frame_tick = ft;
      hit        = h;
      start      = st;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n, input logic f);
      for (int i = 0; i < n; i++) cyc(f, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0;
      ship_h = 10'd320; ship_v = 10'd400;
      @(posedge clk); #1;
      expect_out("reset_state", 1'b0, 1000, 1000, 0);
      cyc(0, 0, 0, 0);
      reset = 1'b1;
      cyc(0, 0, 0, 0);

      // Launch from (320,400) and fly.
      cyc(1, 0, 0, 0);
      expect_out("launch", 1'b1, 320, 380, 1);
      cyc(0, 1, 0, 0);
      expect_out("tick1", 1'b1, 320, 376, 1);
      ticks(4, 1'b0);
      expect_out("tick5", 1'b1, 320, 360, 1);
      ticks(40, 1'b0);
      expect_out("at_200", 1'b1, 320, 200, 1);

      // Fire edge during flight is ignored.
      cyc(1, 0, 0, 0);
      expect_out("fire_in_flight", 1'b1, 320, 200, 1);
      cyc(0, 0, 0, 0);

      // Hit with simultaneous tick retires without moving.
      cyc(0, 1, 1, 0);
      expect_out("hit_retire", 1'b0, 1000, 1000, 1);

      // Fire during cooldown, including one tick before expiry.
      cyc(1, 0, 0, 0);
      expect_out("fire_cooldown", 1'b0, 1000, 1000, 1);
      cyc(0, 0, 0, 0);
      ticks(7, 1'b0);
      cyc(1, 0, 0, 0);
      expect_out("fire_cooldown_last", 1'b0, 1000, 1000, 1);
      cyc(0, 0, 0, 0);
      ticks(1, 1'b0);
      cyc(1, 0, 0, 0);
      expect_out("rearm_launch", 1'b1, 320, 380, 2);
      cyc(0, 0, 1, 0);
      expect_out("hit_retire2", 1'b0, 1000, 1000, 2);
      ticks(8, 1'b0);

      // Launch near the top: v=10 retires on the first tick; fire held.
      ship_v = 10'd30;
      cyc(1, 0, 0, 0);
      expect_out("launch_v10", 1'b1, 320, 10, 3);
      cyc(1, 1, 0, 0);
      expect_out("top_retire", 1'b0, 1000, 1000, 3);
      ticks(8, 1'b1);
      cyc(1, 0, 0, 0);
`ifdef PROJECTILE_AUTOFIRE_EN
      expect_out("held_fire_relaunch", 1'b1, 320, 10, 4);
      cyc(0, 0, 1, 0);
      expect_out("hit_retire3", 1'b0, 1000, 1000, 4);
`else
      expect_out("held_fire_no_launch", 1'b0, 1000, 1000, 3);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expect_out("edge_relaunch", 1'b1, 320, 10, 4);
      cyc(0, 0, 1, 0);
      expect_out("hit_retire3", 1'b0, 1000, 1000, 4);
`endif
      ticks(8, 1'b0);
      cyc(0, 0, 0, 0);

      // Launch saturation: ship_v=5 -> v=0.
      ship_v = 10'd5;
      cyc(1, 0, 0, 0);
      expect_out("launch_sat0", 1'b1, 320, 0, 5);
      cyc(0, 0, 1, 0);
      ticks(8, 1'b0);

      // Drive shots up to 255, then one more wraps to 0.
      ship_v = 10'd400;
      for (int i = 0; i < 250; i++) begin
         cyc(1, 0, 0, 0);
         if (i == 249) expect_out("shots_255", 1'b1, 320, 380, 255);
         cyc(0, 0, 1, 0);
         ticks(8, 1'b0);
      end
      cyc(1, 0, 0, 0);
      expect_out("shots_wrap", 1'b1, 320, 380, 0);
      cyc(0, 0, 0, 0);

      // start mid-flight (with fire, hit, tick) clears everything.
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expect_out("launch_after_start", 1'b1, 320, 380, 1);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 1, 1);
      expect_out("start_midflight", 1'b0, 1000, 1000, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expect_out("idle_after_start", 1'b1, 320, 380, 1);
      cyc(0, 1, 0, 0);

      // Asynchronous reset mid-flight, checked before the next posedge.
      #1 reset = 1'b0;
      expect_out("async_reset", 1'b0, 1000, 1000, 0);
      @(negedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expect_out("launch_after_reset", 1'b1, 320, 380, 1);
      cyc(0, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d unchecked, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/projectile.md
PROJECTILE -- requirements
Module: projectile

Interface
REQ-001 Parameter SPEED, default 4: pixels moved upward per frame_tick.
REQ-002 Parameter TOP_LIMIT, default 10: lowest legal projectile_v; reaching or passing it retires the shot.
REQ-003 Parameter LAUNCH_OFFSET, default 20: launch distance above ship_v.
REQ-004 Parameter COOLDOWN, default 8: frame_ticks between retire and re-arm.
REQ-005 Ports, in order (clock and reset first; name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  synchronous game restart.
- frame_tick  in  1  one-cycle pulse per video frame.
- fire  in  1  player fire button, synchronous to clk.
- ship_h  in  10  ship horizontal position.
- ship_v  in  10  ship vertical position.
- hit  in  1  collision flag from the enemy block.
- projectile_h  out  10  projectile horizontal position.
- projectile_v  out  10  projectile vertical position.
- active  out  1  projectile in flight.
- shots  out  8  count of shots launched.

Function
REQ-006 The FSM SHALL be one-hot with states IDLE, FLIGHT and COOLDOWN.
REQ-007 A shot request SHALL be a fire rising edge (fire=1 and fire_prev=0); fire_prev is registered every cycle.
REQ-008 In IDLE, a shot request on cycle N SHALL produce the following at N+1:
- state = FLIGHT.
- active = 1.
- projectile_h = ship_h.
- projectile_v = ship_v - LAUNCH_OFFSET, saturated at 0.
- shots incremented by 1, wrapping 255->0.
REQ-009 In FLIGHT, on frame_tick: if projectile_v <= TOP_LIMIT + SPEED, the shot SHALL retire; otherwise projectile_v SHALL decrease by SPEED. projectile_h SHALL stay constant.
REQ-010 In FLIGHT, hit=1 SHALL retire the shot on the next edge. hit takes priority over a simultaneous frame_tick, and the position is not updated.
REQ-011 A launch with projectile_v <= TOP_LIMIT SHALL retire on the first frame_tick.
REQ-012 Retire SHALL perform all of the following on the same edge:
- active = 0.
- projectile_h = projectile_v = 10'd1000 (parked off-screen).
- cooldown counter loaded with COOLDOWN.
- state = COOLDOWN.
REQ-013 In COOLDOWN, each frame_tick SHALL decrement the counter; when it reaches 0 the FSM SHALL return to IDLE. With COOLDOWN=0, it returns to IDLE on the first frame_tick.
REQ-014 fire and hit SHALL be ignored outside the states where this document gives them an effect.
REQ-015 start=1 SHALL, from any state and on the next edge:
- state = IDLE.
- active = 0.
- position parked.
- shots = 0.
- cooldown counter = 0.
start beats fire, hit and frame_tick on the same cycle.
REQ-016 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-017 On reset=0, asynchronously: state = IDLE, active = 0, projectile_h = projectile_v = 10'd1000, shots = 0, cooldown counter = 0, fire_prev = 0.
REQ-018 Reset asserted mid-flight SHALL abort the shot immediately, with no retire sequence and no cooldown.

Configuration
REQ-019 Macro PROJECTILE_AUTOFIRE_EN:
- Defined: a shot request in IDLE is fire=1 (level), so holding fire re-launches as soon as IDLE is re-entered.
- Undefined: edge-only firing per REQ-007.

Verification
REQ-020 Bench SHALL cover these directed scenarios (default parameters, stimulus -> required response):
- ship=(320,400), fire edge -> next cycle active=1, pos=(320,380), shots=1; 5 frame_ticks -> v=360.
- In flight at v=200, hit and frame_tick on the same cycle -> v stays 200, then active=0, pos=(1000,1000), COOLDOWN.
- ship_v=30, fire -> v=10; first frame_tick retires; 8 frame_ticks later IDLE; fire held throughout relaunches only if PROJECTILE_AUTOFIRE_EN is defined.
- Fire during FLIGHT and during COOLDOWN -> no launch, shots unchanged.
- shots=255, fire -> shots=0.
- Mid-flight, start=1 with fire=1 -> IDLE, parked, shots=0; reset=0 asynchronously yields the REQ-017 values before the next edge.
